// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular in-order retirement buffer. Allocates one entry per
//                cycle at the tail (tag = slot + 1, tag 0 = no producer),
//                marks entries done from the CDB in any order, and retires
//                at most one entry per cycle from the head. A retiring
//                mispredicted branch flushes the whole buffer and raises a
//                one-cycle redirect pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 5,
    parameter int DATA_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [4:0]        alloc_rd,
    input  logic              alloc_is_store,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_mispredict,
    input  logic [DATA_W-1:0] cdb_target,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [4:0]        commit_rd,
    output logic [DATA_W-1:0] commit_value,
    output logic              commit_store,
    output logic              flush,
    output logic [DATA_W-1:0] flush_pc,
    output logic [TAG_W-1:0]  count
);

    // Slot index width; ROB_SIZE is a power of two so pointers wrap naturally.
    localparam int                 c_idx_w    = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam logic [TAG_W-1:0]   c_rob_full = TAG_W'(ROB_SIZE);
    localparam logic [TAG_W-1:0]   c_tag_one  = TAG_W'(1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    // ------------------------------------------------------------------------
    // Entry storage: status bits are reset, payload fields are not (they are
    // only ever read behind a set valid bit).
    // ------------------------------------------------------------------------
    logic [ROB_SIZE-1:0] r_valid;
    logic [ROB_SIZE-1:0] r_done;
    logic [ROB_SIZE-1:0] r_mispredict;
    logic [ROB_SIZE-1:0] r_is_store;
    logic [4:0]          r_rd     [ROB_SIZE];
    logic [DATA_W-1:0]   r_value  [ROB_SIZE];
    logic [DATA_W-1:0]   r_target [ROB_SIZE];

    logic [c_idx_w-1:0]  r_head;
    logic [c_idx_w-1:0]  r_tail;
    logic [TAG_W-1:0]    r_count;

    // Registered retirement / redirect outputs.
    logic                r_commit_valid;
    logic [TAG_W-1:0]    r_commit_tag;
    logic [4:0]          r_commit_rd;
    logic [DATA_W-1:0]   r_commit_value;
    logic                r_commit_store;
    logic                r_flush;
    logic [DATA_W-1:0]   r_flush_pc;

    // ------------------------------------------------------------------------
    // Combinational decode of this cycle's events
    // ------------------------------------------------------------------------
    logic               w_alloc_fire;
    logic               w_cdb_in_range;
    logic [c_idx_w-1:0] w_cdb_idx;
    logic               w_cdb_hit;
    logic               w_commit;
    logic               w_flush_now;

    // Full check looks at the current count only: a retirement in the same
    // cycle does not open a slot until the following cycle.
    assign alloc_ready    = reset && !r_flush && (r_count < c_rob_full);
    assign alloc_tag      = TAG_W'(r_tail) + c_tag_one;
    assign w_alloc_fire   = alloc_valid && alloc_ready;

    // Range check must precede the index truncation, otherwise a tag above
    // ROB_SIZE would alias onto a low slot.
    assign w_cdb_in_range = (cdb_tag != '0) && (cdb_tag <= c_rob_full);
    assign w_cdb_idx      = c_idx_w'(cdb_tag - c_tag_one);
    assign w_cdb_hit      = cdb_valid && w_cdb_in_range && r_valid[w_cdb_idx];

    // Retirement uses pre-edge done bits, so a CDB write to the head slot
    // retires one edge later, never on the edge that records it.
    assign w_commit       = r_valid[r_head] && r_done[r_head];
    assign w_flush_now    = w_commit && r_mispredict[r_head];

    // ------------------------------------------------------------------------
    // Pointers, count and entry status bits
    // ------------------------------------------------------------------------
    // Status/pointer update: reset and flush clear everything; otherwise
    // allocate at tail, mark CDB hits done, and release the head on retire.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else if (w_flush_now) begin
            // Any same-cycle allocation or CDB write is squashed with the rest.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            // A valid tail slot implies full, so alloc never collides with a
            // CDB hit or a retirement on the same slot.
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + c_idx_one;
            end
            if (w_cdb_hit) begin
                r_done[w_cdb_idx] <= 1'b1;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_idx_one;
            end
            case ({w_alloc_fire, w_commit})
                2'b10:   r_count <= r_count + c_tag_one;
                2'b01:   r_count <= r_count - c_tag_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Entry payload
    // ------------------------------------------------------------------------
    // Payload capture: destination info at allocation, result and branch
    // outcome at writeback.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_rd[r_tail]         <= alloc_rd;
            r_is_store[r_tail]   <= alloc_is_store;
            r_mispredict[r_tail] <= 1'b0;
        end
        if (w_cdb_hit) begin
            r_value[w_cdb_idx]      <= cdb_value;
            r_mispredict[w_cdb_idx] <= cdb_mispredict;
            r_target[w_cdb_idx]     <= cdb_target;
        end
    end

    // ------------------------------------------------------------------------
    // Retirement and redirect outputs
    // ------------------------------------------------------------------------
    // Retire register: present the head entry for one cycle; a mispredicted
    // head still retires (its rd write is architectural) and also redirects.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_commit_valid <= 1'b0;
            r_commit_tag   <= '0;
            r_commit_rd    <= '0;
            r_commit_value <= '0;
            r_commit_store <= 1'b0;
            r_flush        <= 1'b0;
            r_flush_pc     <= '0;
        end else begin
            r_commit_valid <= w_commit;
            if (w_commit) begin
                r_commit_tag   <= TAG_W'(r_head) + c_tag_one;
                r_commit_rd    <= r_rd[r_head];
                r_commit_value <= r_value[r_head];
                r_commit_store <= r_is_store[r_head];
            end
            r_flush    <= w_flush_now;
            r_flush_pc <= w_flush_now ? r_target[r_head] : '0;
        end
    end

    assign commit_valid = r_commit_valid;
    assign commit_tag   = r_commit_tag;
    assign commit_rd    = r_commit_rd;
    assign commit_value = r_commit_value;
    assign commit_store = r_commit_store;
    assign flush        = r_flush;
    assign flush_pc     = r_flush_pc;
    assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_buffer
//  Description : Self-checking bench for reorder_buffer: a table of
//                single-cycle vectors (inputs + expected post-edge outputs)
//                followed by a hand-written full/wrap sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_rd;
    logic        alloc_is_store;
    logic [4:0]  alloc_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        cdb_mispredict;
    logic [63:0] cdb_target;
    logic        commit_valid;
    logic [4:0]  commit_tag;
    logic [4:0]  commit_rd;
    logic [63:0] commit_value;
    logic        commit_store;
    logic        flush;
    logic [63:0] flush_pc;
    logic [4:0]  count;

    int checks   = 0;
    int failures = 0;

    reorder_buffer #(.ROB_SIZE(16), .TAG_W(5), .DATA_W(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_rd       (alloc_rd),
        .alloc_is_store (alloc_is_store),
        .alloc_tag      (alloc_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .cdb_mispredict (cdb_mispredict),
        .cdb_target     (cdb_target),
        .commit_valid   (commit_valid),
        .commit_tag     (commit_tag),
        .commit_rd      (commit_rd),
        .commit_value   (commit_value),
        .commit_store   (commit_store),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        av;
        logic [4:0]  rd;
        logic        st;
        logic        cv;
        logic [4:0]  ctag;
        logic [63:0] cval;
        logic        mp;
        logic [63:0] tgt;
        logic        e_cv;
        logic [4:0]  e_tag;
        logic [4:0]  e_rd;
        logic [63:0] e_val;
        logic        e_st;
        logic        e_fl;
        logic [63:0] e_fpc;
        logic [4:0]  e_cnt;
        logic        e_ardy;
        logic [4:0]  e_atag;
        logic        e_chk;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic rst_n, input logic av, input logic [4:0] rd, input logic st,
        input logic cv, input logic [4:0] ctag, input logic [63:0] cval, input logic mp, input logic [63:0] tgt,
        input logic e_cv, input logic [4:0] e_tag, input logic [4:0] e_rd, input logic [63:0] e_val, input logic e_st,
        input logic e_fl, input logic [63:0] e_fpc, input logic [4:0] e_cnt, input logic e_ardy, input logic [4:0] e_atag,
        input logic e_chk);
        vec_t v;
        v.rst_n = rst_n; v.av = av; v.rd = rd; v.st = st;
        v.cv = cv; v.ctag = ctag; v.cval = cval; v.mp = mp; v.tgt = tgt;
        v.e_cv = e_cv; v.e_tag = e_tag; v.e_rd = e_rd; v.e_val = e_val; v.e_st = e_st;
        v.e_fl = e_fl; v.e_fpc = e_fpc; v.e_cnt = e_cnt; v.e_ardy = e_ardy; v.e_atag = e_atag;
        v.e_chk = e_chk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid    = 1'b0;
        alloc_rd       = '0;
        alloc_is_store = 1'b0;
        cdb_valid      = 1'b0;
        cdb_tag        = '0;
        cdb_value      = '0;
        cdb_mispredict = 1'b0;
        cdb_target     = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        //        rst av rd st  cv tag val      mp tgt      | e_cv tag rd val      st fl fpc      cnt rdy atag chk
        // reset (twice) with zeroed retire outputs
        vt.push_back(mk(0, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 1, 1));
        // three allocations rd 5,6,7 -> tags 1,2,3
        vt.push_back(mk(1, 1, 5, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    1, 1, 2, 0));
        vt.push_back(mk(1, 1, 6, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    2, 1, 3, 0));
        vt.push_back(mk(1, 1, 7, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    3, 1, 4, 0));
        // out-of-order completion 3,1,2 -> in-order retire 1,2,3
        vt.push_back(mk(1, 0, 0, 0,  1, 3, 64'h33,   0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    3, 1, 4, 0));
        vt.push_back(mk(1, 0, 0, 0,  1, 1, 64'h11,   0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    3, 1, 4, 0));
        vt.push_back(mk(1, 0, 0, 0,  1, 2, 64'h22,   0, 64'h0,     1, 1, 5, 64'h11,   0, 0, 64'h0,    2, 1, 4, 1));
        vt.push_back(mk(1, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     1, 2, 6, 64'h22,   0, 0, 64'h0,    1, 1, 4, 1));
        vt.push_back(mk(1, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     1, 3, 7, 64'h33,   0, 0, 64'h0,    0, 1, 4, 1));
        vt.push_back(mk(1, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 1, 4, 0));
        // mispredict: alloc tags 4,5(store),6; tag5 mispredicts to 0x1000
        vt.push_back(mk(1, 1, 1, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    1, 1, 5, 0));
        vt.push_back(mk(1, 1, 2, 1,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    2, 1, 6, 0));
        vt.push_back(mk(1, 1, 3, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    3, 1, 7, 0));
        vt.push_back(mk(1, 0, 0, 0,  1, 5, 64'h55,   1, 64'h1000,  0, 0, 0, 64'h0,    0, 0, 64'h0,    3, 1, 7, 0));
        vt.push_back(mk(1, 0, 0, 0,  1, 4, 64'h44,   0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    3, 1, 7, 0));
        vt.push_back(mk(1, 0, 0, 0,  1, 6, 64'h66,   0, 64'h0,     1, 4, 1, 64'h44,   0, 0, 64'h0,    2, 1, 7, 1));
        vt.push_back(mk(1, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     1, 5, 2, 64'h55,   1, 1, 64'h1000, 0, 0, 1, 1));
        vt.push_back(mk(1, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 1, 1, 0));
        vt.push_back(mk(1, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 1, 1, 0));
        // two live entries; ignored CDB tags 0, 9 (invalid slot), 17 (out of range, aliases slot 0)
        vt.push_back(mk(1, 1, 8, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    1, 1, 2, 0));
        vt.push_back(mk(1, 1, 9, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    2, 1, 3, 0));
        vt.push_back(mk(1, 0, 0, 0,  1, 0, 64'hdead, 1, 64'h2000,  0, 0, 0, 64'h0,    0, 0, 64'h0,    2, 1, 3, 0));
        vt.push_back(mk(1, 0, 0, 0,  1, 9, 64'hdead, 1, 64'h2000,  0, 0, 0, 64'h0,    0, 0, 64'h0,    2, 1, 3, 0));
        vt.push_back(mk(1, 0, 0, 0,  1, 17, 64'hdead, 1, 64'h2000, 0, 0, 0, 64'h0,    0, 0, 64'h0,    2, 1, 3, 0));
        vt.push_back(mk(1, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    2, 1, 3, 0));
        // mid-stream reset with 4 live, 2 done; reset overrides alloc/CDB
        vt.push_back(mk(1, 1, 10, 0, 0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    3, 1, 4, 0));
        vt.push_back(mk(1, 1, 11, 0, 1, 2, 64'h22,   0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    4, 1, 5, 0));
        vt.push_back(mk(1, 0, 0, 0,  1, 3, 64'h33,   0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    4, 1, 5, 0));
        vt.push_back(mk(0, 1, 12, 0, 1, 1, 64'h11,   0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 0, 1, 1));
        vt.push_back(mk(1, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 1, 1, 0));
        vt.push_back(mk(1, 0, 0, 0,  0, 0, 64'h0,    0, 64'h0,     0, 0, 0, 64'h0,    0, 0, 64'h0,    0, 1, 1, 0));

        for (int i = 0; i < vt.size(); i++) begin
            reset          = vt[i].rst_n;
            alloc_valid    = vt[i].av;
            alloc_rd       = vt[i].rd;
            alloc_is_store = vt[i].st;
            cdb_valid      = vt[i].cv;
            cdb_tag        = vt[i].ctag;
            cdb_value      = vt[i].cval;
            cdb_mispredict = vt[i].mp;
            cdb_target     = vt[i].tgt;
            step();
            chk($sformatf("v%0d_commit_valid", i), 64'(commit_valid), 64'(vt[i].e_cv));
            chk($sformatf("v%0d_flush", i),        64'(flush),        64'(vt[i].e_fl));
            chk($sformatf("v%0d_flush_pc", i),     flush_pc,          vt[i].e_fpc);
            chk($sformatf("v%0d_count", i),        64'(count),        64'(vt[i].e_cnt));
            chk($sformatf("v%0d_alloc_ready", i),  64'(alloc_ready),  64'(vt[i].e_ardy));
            chk($sformatf("v%0d_alloc_tag", i),    64'(alloc_tag),    64'(vt[i].e_atag));
            if (vt[i].e_chk) begin
                chk($sformatf("v%0d_commit_tag", i),   64'(commit_tag),   64'(vt[i].e_tag));
                chk($sformatf("v%0d_commit_rd", i),    64'(commit_rd),    64'(vt[i].e_rd));
                chk($sformatf("v%0d_commit_value", i), commit_value,      vt[i].e_val);
                chk($sformatf("v%0d_commit_store", i), 64'(commit_store), 64'(vt[i].e_st));
            end
        end

        // ---------------- fill to 16, refuse 17th, retire, wrap ------------
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = 5'(i + 1);
            chk($sformatf("fill%0d_tag", i),   64'(alloc_tag),   64'(i + 1));
            chk($sformatf("fill%0d_ready", i), 64'(alloc_ready), 64'd1);
            step();
        end
        chk("full_count", 64'(count),       64'd16);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        chk("full_tag",   64'(alloc_tag),   64'd1);

        alloc_rd = 5'd31;
        step();
        chk("alloc17_count",  64'(count),        64'd16);
        chk("alloc17_commit", 64'(commit_valid), 64'd0);

        cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_value = 64'hAA;
        step();
        chk("cdb1_same_edge_commit", 64'(commit_valid), 64'd0);
        chk("cdb1_count",            64'(count),        64'd16);
        chk("cdb1_ready",            64'(alloc_ready),  64'd0);

        cdb_valid = 1'b0;
        step();
        chk("ret1_valid", 64'(commit_valid), 64'd1);
        chk("ret1_tag",   64'(commit_tag),   64'd1);
        chk("ret1_rd",    64'(commit_rd),    64'd1);
        chk("ret1_value", commit_value,      64'hAA);
        chk("ret1_count_no_bypass", 64'(count), 64'd15);
        chk("ret1_ready", 64'(alloc_ready),  64'd1);
        chk("wrap_tag",   64'(alloc_tag),    64'd1);

        step();
        chk("wrap_alloc_count",  64'(count),        64'd16);
        chk("wrap_alloc_commit", 64'(commit_valid), 64'd0);

        alloc_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_value = 64'hBB;
        step();
        cdb_valid = 1'b0;
        step();
        chk("ret2_valid", 64'(commit_valid), 64'd1);
        chk("ret2_tag",   64'(commit_tag),   64'd2);
        chk("ret2_value", commit_value,      64'hBB);
        chk("ret2_count", 64'(count),        64'd15);

        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_value = 64'hCC;
        step();
        chk("cdb3_count", 64'(count), 64'd15);

        // retirement and allocation on the same edge leave count unchanged
        cdb_valid = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd20;
        chk("both_alloc_tag", 64'(alloc_tag), 64'd2);
        step();
        chk("both_commit_valid", 64'(commit_valid), 64'd1);
        chk("both_commit_tag",   64'(commit_tag),   64'd3);
        chk("both_commit_value", commit_value,      64'hCC);
        chk("both_count",        64'(count),        64'd15);
        chk("both_next_tag",     64'(alloc_tag),    64'd3);

        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
